arbitro_rr_8: RTL

- Round-robin arbiter that shares one 8:1 datapath multiplexer among eight requesters.
- Produces a one-hot grant and a 3-bit select code for the mux SEL input, plus a valid flag that qualifies the mux output.
- Enforces a bounded hold time per grant and inserts one idle cycle at every ownership change, so the mux select never switches while a consumer samples data.

---
 rtl/arbitro_pkg.sv | 12 +
 rtl/prioridade_rr_8.sv | 31 +++
 rtl/arbitro_rr_8.sv | 100 ++++++++++
 3 files changed

// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared constants and state type for the round-robin mux arbiter
package arbitro_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    OCIOSO    = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

endpackage

// File: rtl/prioridade_rr_8.sv
// rtl/prioridade_rr_8.sv - combinational rotating priority encoder starting the scan at PTR
module prioridade_rr_8
  import arbitro_pkg::*;
(
  input  logic [N_REQ-1:0] REQ,
  input  logic [SEL_W-1:0] PTR,
  output logic [SEL_W-1:0] IDX,
  output logic             ANY
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] pos;
  logic [SEL_W-1:0] enc;

  // rotate so PTR lands on bit 0, pick the lowest set bit, then undo the rotation
  always_comb begin
    rot = '0;
    pos = '0;
    enc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos    = SEL_W'(i) + PTR;
      rot[i] = REQ[pos];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = SEL_W'(i);
    end
    IDX = enc + PTR;
    ANY = |REQ;
  end

endmodule

// File: rtl/arbitro_rr_8.sv
// rtl/arbitro_rr_8.sv - round-robin arbiter for a shared 8:1 mux with bounded hold and idle handover
module arbitro_rr_8
  import arbitro_pkg::*;
#(
  parameter int MAX_CICLOS = 16,
  parameter int CW         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic [SEL_W-1:0] SEL,
  output logic             VALID,
  output logic             PREEMPT
);

  localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_CICLOS - 1);
  localparam logic [N_REQ-1:0] UM      = {{(N_REQ-1){1'b0}}, 1'b1};

  estado_t          estado, estado_d;
  logic [SEL_W-1:0] ptr, ptr_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [N_REQ-1:0] gnt_d;
  logic [SEL_W-1:0] sel_d;
  logic             valid_d;
  logic             preempt_d;
  logic [SEL_W-1:0] idx;
  logic             any_req;
  logic             outros;

  prioridade_rr_8 u_prio (
    .REQ (REQ),
    .PTR (ptr),
    .IDX (idx),
    .ANY (any_req)
  );

  // state, pointer, hold counter and all outputs are registered together; reset wins over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      ptr     <= '0;
      cnt     <= '0;
      GNT     <= '0;
      SEL     <= '0;
      VALID   <= 1'b0;
      PREEMPT <= 1'b0;
    end else begin
      estado  <= estado_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
      GNT     <= gnt_d;
      SEL     <= sel_d;
      VALID   <= valid_d;
      PREEMPT <= preempt_d;
    end
  end

  // next-state: grant from idle, release or timeout back to idle (always one idle cycle between owners)
  always_comb begin
    estado_d  = estado;
    ptr_d     = ptr;
    cnt_d     = cnt;
    gnt_d     = GNT;
    sel_d     = SEL;
    valid_d   = VALID;
    preempt_d = 1'b0;
    outros    = |(REQ & ~GNT);
    case (estado)
      OCIOSO: begin
        if (any_req) begin
          gnt_d    = UM << idx;
          sel_d    = idx;
          valid_d  = 1'b1;
          cnt_d    = '0;
          estado_d = CONCEDIDO;
        end
      end
      CONCEDIDO: begin
        if (!REQ[SEL]) begin
          gnt_d    = '0;
          valid_d  = 1'b0;
          ptr_d    = SEL + SEL_W'(1);
          estado_d = OCIOSO;
        end else if (cnt == CNT_MAX && outros) begin
          gnt_d     = '0;
          valid_d   = 1'b0;
          preempt_d = 1'b1;
          ptr_d     = SEL + SEL_W'(1);
          estado_d  = OCIOSO;
        end else if (cnt != CNT_MAX) begin
          // saturating so a lone owner keeps the grant indefinitely
          cnt_d = cnt + CW'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

endmodule
